// File: rtl/fir_pkg.sv
// Shared definitions for the decimating FIR audio low-pass stage:
// FSM state encoding, default geometry, Q10 coefficient table,
// accumulator width and the saturating narrow helper.
package fir_pkg;

  localparam int FIR_TAPS       = 32;
  localparam int FIR_DECIMATION = 8;
  localparam int FIR_FRAC_BITS  = 10;
  localparam int FIR_DATA_WIDTH = 32;

  // Full-precision products plus headroom for summing every tap.
  localparam int ACC_WIDTH = 2 * FIR_DATA_WIDTH + $clog2(FIR_TAPS);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // Low-pass taps in Q10, all distinct and all positive (sum = 2465),
  // so an impulse reveals each tap and a full-scale DC input overflows.
  localparam logic signed [FIR_DATA_WIDTH-1:0] AUDIO_LPF_COEFFS [FIR_TAPS] = '{
    32'sd3,   32'sd7,   32'sd12,  32'sd18,  32'sd26,  32'sd35,  32'sd46,  32'sd58,
    32'sd71,  32'sd85,  32'sd99,  32'sd113, 32'sd126, 32'sd138, 32'sd148, 32'sd155,
    32'sd159, 32'sd156, 32'sd150, 32'sd141, 32'sd129, 32'sd116, 32'sd102, 32'sd88,
    32'sd74,  32'sd60,  32'sd47,  32'sd36,  32'sd27,  32'sd19,  32'sd13,  32'sd8
  };

  // Clamp a wide signed value into the signed sample range.
  function automatic logic signed [FIR_DATA_WIDTH-1:0] sat_to_data(
    input logic signed [ACC_WIDTH-1:0] value
  );
    logic signed [ACC_WIDTH-1:0]      max_v;
    logic signed [ACC_WIDTH-1:0]      min_v;
    logic signed [FIR_DATA_WIDTH-1:0] res;
    max_v = {{(ACC_WIDTH-FIR_DATA_WIDTH+1){1'b0}}, {(FIR_DATA_WIDTH-1){1'b1}}};
    min_v = ~max_v;
    if (value > max_v) begin
      res = {1'b0, {(FIR_DATA_WIDTH-1){1'b1}}};
    end else if (value < min_v) begin
      res = {1'b1, {(FIR_DATA_WIDTH-1){1'b0}}};
    end else begin
      res = value[FIR_DATA_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate for fir_decimate.
// clr zeroes the accumulator, en adds sample*coeff. result is the
// next accumulator value shifted right by FRAC_BITS and narrowed to
// DATA_WIDTH, so the caller can register the final sum on the same
// edge that accumulates the last tap.
// Macro FIR_SATURATE_EN: clamp the narrowed result instead of wrapping.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int ACC_W      = ACC_WIDTH,
  parameter int FRAC_BITS  = FIR_FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] coeff,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [2*DATA_WIDTH-1:0] sample_ext_s;
  logic signed [2*DATA_WIDTH-1:0] coeff_ext_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]        prod_wide_s;
  logic signed [ACC_W-1:0]        acc_d;
  logic signed [ACC_W-1:0]        acc_q;

  // Full-width signed product, sign-extended to accumulator width.
  always_comb begin
    sample_ext_s = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};
    coeff_ext_s  = {{DATA_WIDTH{coeff[DATA_WIDTH-1]}}, coeff};
    prod_s       = sample_ext_s * coeff_ext_s;
    prod_wide_s  = {{(ACC_W-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
  end

  // Next accumulator value: clear has priority over accumulate.
  always_comb begin
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en) begin
      acc_d = acc_q + prod_wide_s;
    end else begin
      acc_d = acc_q;
    end
  end

`ifdef FIR_SATURATE_EN
  logic signed [ACC_W-1:0] shifted_s;

  // Scale back from Q10 and clamp into the sample range.
  always_comb begin
    shifted_s = acc_d >>> FRAC_BITS;
    result    = sat_to_data(shifted_s);
  end
`else
  // Scale back from Q10 keeping the low sample bits (two's-complement wrap).
  always_comb begin
    result = acc_d[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];
  end
`endif

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_decimate.sv
// Decimating FIR stage: pops DECIMATION samples from an FWFT FIFO into
// a TAPS-deep shift register, runs one MAC per tap, then pushes one
// filtered sample downstream. Input is only read while loading, so the
// upstream FIFO simply backs up during MAC and write.
// Macro FIR_SATURATE_EN: saturate the output instead of wrapping.
module fir_decimate
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DECIMATION = FIR_DECIMATION,
  parameter int FRAC_BITS  = FIR_FRAC_BITS,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         in_rd_en,
  input  logic                         in_empty,
  input  logic signed [DATA_WIDTH-1:0] in_dout,
  output logic                         out_wr_en,
  input  logic                         out_full,
  output logic signed [DATA_WIDTH-1:0] out_din
);

  localparam int TCW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int LCW   = $clog2(DECIMATION + 1);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(TAPS);

  localparam logic [TCW-1:0] LAST_TAP  = TCW'(TAPS - 1);
  localparam logic [LCW-1:0] LAST_LOAD = LCW'(DECIMATION - 1);
  localparam logic [TCW-1:0] TAP_ONE   = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [LCW-1:0] LOAD_ONE  = {{(LCW-1){1'b0}}, 1'b1};

  state_e                       state_d, state_q;
  logic [LCW-1:0]               load_cnt_d, load_cnt_q;
  logic [TCW-1:0]               tap_cnt_d, tap_cnt_q;
  logic signed [DATA_WIDTH-1:0] x_d [TAPS];
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [DATA_WIDTH-1:0] out_din_d, out_din_q;

  logic                         pop_s;
  logic                         push_s;
  logic                         mac_clr_s;
  logic                         mac_en_s;
  logic signed [DATA_WIDTH-1:0] mac_result_s;

  // FIFO handshakes: only pop while loading, only push while writing;
  // both held low during reset.
  always_comb begin
    pop_s  = rst_n & (state_q == S_LOAD)  & ~in_empty;
    push_s = rst_n & (state_q == S_WRITE) & ~out_full;
  end

  assign in_rd_en  = pop_s;
  assign out_wr_en = push_s;
  assign out_din   = out_din_q;

  // FSM, counters and shift register next-state logic.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    tap_cnt_d  = tap_cnt_q;
    out_din_d  = out_din_q;
    x_d        = x_q;
    mac_clr_s  = 1'b0;
    mac_en_s   = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (pop_s) begin
          x_d[0] = in_dout;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          if (load_cnt_q == LAST_LOAD) begin
            load_cnt_d = {LCW{1'b0}};
            tap_cnt_d  = {TCW{1'b0}};
            mac_clr_s  = 1'b1;
            state_d    = S_MAC;
          end else begin
            load_cnt_d = load_cnt_q + LOAD_ONE;
          end
        end else begin
          load_cnt_d = load_cnt_q;
        end
      end
      S_MAC: begin
        mac_en_s = 1'b1;
        if (tap_cnt_q == LAST_TAP) begin
          // mac_result_s already includes this final tap.
          out_din_d = mac_result_s;
          tap_cnt_d = {TCW{1'b0}};
          state_d   = S_WRITE;
        end else begin
          tap_cnt_d = tap_cnt_q + TAP_ONE;
        end
      end
      S_WRITE: begin
        if (push_s) begin
          load_cnt_d = {LCW{1'b0}};
          state_d    = S_LOAD;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .sample (x_q[tap_cnt_q]),
    .coeff  (AUDIO_LPF_COEFFS[tap_cnt_q]),
    .result (mac_result_s)
  );

  // State, counters, shift register and output sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_cnt_q <= {LCW{1'b0}};
      tap_cnt_q  <= {TCW{1'b0}};
      out_din_q  <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      tap_cnt_q  <= tap_cnt_d;
      out_din_q  <= out_din_d;
      x_q        <= x_d;
    end
  end

endmodule

// File: doc/fir_decimate.md
# fir_decimate

Decimating FIR filter stage for the FM receiver's audio path. Consumes the 32-bit signed sample stream produced by the two-input multiply stage (e.g. demodulated L−R mixing) through a first-word-fall-through (FWFT) FIFO. Low-pass filters it with a fixed Q10 coefficient set and emits one sample per DECIMATION inputs into a downstream FIFO.

## Interface
- TAPS, 32, number of filter taps (≥ DECIMATION, power of two not required)
- DECIMATION, 8, input samples consumed per output sample
- FRAC_BITS, 10, fractional bits of coefficients; result scaled by arithmetic right shift
- DATA_WIDTH, 32, sample width (signed)

- clock  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- in_rd_en  output  1  pops upstream FIFO
- in_empty  input  1  upstream FIFO empty
- in_dout  input  DATA_WIDTH  upstream FWFT head sample (signed)
- out_wr_en  output  1  pushes downstream FIFO
- out_full  input  1  downstream FIFO full
- out_din  output  DATA_WIDTH  filtered sample (signed)

## Operation
- State machine: S_LOAD → S_MAC → S_WRITE → S_LOAD.
- S_LOAD: in_rd_en = !in_empty (combinational). On each pop, shift register x[TAPS-1:0] shifts toward the higher index: x[0] ← in_dout, oldest sample discarded. load_cnt increments. When DECIMATION samples are popped, clear acc and tap_cnt, then go to S_MAC.
- S_MAC: one tap per cycle, acc += x[tap_cnt] * COEFFS[tap_cnt].
  - Product is full 2·DATA_WIDTH signed.
  - acc is 2·DATA_WIDTH + clog2(TAPS) bits signed.
  - After tap TAPS-1 is accumulated: result = acc >>> FRAC_BITS, narrowed to DATA_WIDTH (see Configuration). Result is registered into out_din, then go to S_WRITE.
- S_WRITE: out_wr_en = !out_full (combinational). On the cycle out_wr_en is high, return to S_LOAD with load_cnt = 0. out_din holds until the next result is registered.
- No input is read outside S_LOAD. Upstream backs up naturally while the block is in S_MAC or S_WRITE.
- Reset: asynchronous and immediate, from any state.
  - State → S_LOAD; x[], acc, load_cnt, tap_cnt, out_din → 0.
  - in_rd_en and out_wr_en are forced 0 while reset is low.
  - A MAC in progress is discarded with no partial output.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0.
- Input rate: at most one pop per cycle. in_empty high stalls S_LOAD indefinitely without corrupting load_cnt.
- Latency: the DECIMATION-th pop is at cycle N. The first MAC is at N+1 and the last at N+TAPS. out_din is valid and out_wr_en can assert at N+TAPS+1 if out_full is low.
- Best-case period per output: DECIMATION + TAPS + 1 cycles.
- out_full high in S_WRITE: out_wr_en stays 0 and out_din stays stable. The write fires on the first cycle out_full is low.
- Simultaneous in_empty deassert and state change: a pop only occurs in S_LOAD. The state transition out of S_LOAD happens on the same edge as the final pop.

## Configuration
- FIR_SATURATE_EN defined: the shifted result is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] before registering.
- FIR_SATURATE_EN undefined: the shifted result is truncated to its low DATA_WIDTH bits (two's-complement wrap).

## Structure
- Package fir_pkg contains:
  - state enum (S_LOAD, S_MAC, S_WRITE);
  - localparam AUDIO_LPF_COEFFS[TAPS] as signed DATA_WIDTH Q10 values;
  - ACC_WIDTH computation;
  - saturation helper function.
- Sub-module fir_mac: registered multiply-accumulate with clear and enable inputs. It holds acc and exposes the shifted result. The top holds the FSM, counters, shift register and FIFO handshakes.

## Test plan
- Impulse: input 1024 then 63 zeros, coefficients distinct → outputs are COEFFS[7], COEFFS[15], COEFFS[23], COEFFS[31], then 0 (x[7] holds the impulse at the first output).
- DC: constant input 1024 for 64 samples → from the 4th output onward, each output equals sum(COEFFS) exactly.
- Backpressure: out_full held high 50 cycles during S_WRITE → out_wr_en=0 throughout, out_din stable, no input popped. After release, one write, and the sequence matches the unstalled golden file.
- Upstream gaps: in_empty toggled randomly at 50% → output sequence identical to the gap-free run.
- Reset mid-MAC: reset low for 2 cycles at tap 10 of the 2nd output → no write for that output. After release the outputs match a fresh run from a zero shift register.
- Overflow: input 0x7FFFFFFF sustained with positive-sum coefficients. With FIR_SATURATE_EN → 0x7FFFFFFF. Without → the golden model's low-32-bit wrapped value.
